// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds every downstream reset domain, then releases them one
// at a time in index order, each gated by its ready ack (or a timeout) plus a gap.
module rst_seq_ctrl #(
    parameter int NUM_STAGE   = 3,
    parameter int HOLD_CYCLE  = 8,
    parameter int STAGE_DLY   = 16,
    parameter int ACK_TIMEOUT = 255,
    localparam int SW = (NUM_STAGE > 1) ? $clog2(NUM_STAGE) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_soft_rst,
    input  logic [NUM_STAGE-1:0] i_stage_ack,
    output logic [NUM_STAGE-1:0] o_stage_rst,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout_err,
    output logic [SW-1:0]        o_cur_stage
);

    localparam int MAX_A = (HOLD_CYCLE > STAGE_DLY) ? HOLD_CYCLE : STAGE_DLY;
    localparam int MAX_V = (MAX_A > ACK_TIMEOUT) ? MAX_A : ACK_TIMEOUT;
    localparam int CW    = $clog2(MAX_V + 1);

    // Each terminal value is one less than the cycle count, because the
    // counter is cleared on the edge that enters the state.
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLE - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((STAGE_DLY > 0) ? STAGE_DLY - 1 : 0);
    localparam logic [CW-1:0] ACK_LAST   = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGE - 1);

    typedef enum logic [1:0] {
        HOLD,
        WAIT_ACK,
        GAP,
        DONE
    } state_t;

    state_t               state_reg;
    logic [CW-1:0]        cnt_reg;
    logic [NUM_STAGE-1:0] cur_sel;
    logic                 ack_hit;
    logic                 tmo_hit;
    logic                 stage_end;
    logic                 last_stage;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGE; gi++) begin : g_sel
            assign cur_sel[gi] = (o_cur_stage == SW'(gi));
        end
    endgenerate

    assign ack_hit    = |(i_stage_ack & cur_sel);
    assign tmo_hit    = (ACK_TIMEOUT != 0) && (cnt_reg == ACK_LAST);
    assign stage_end  = ack_hit || tmo_hit || (ACK_TIMEOUT == 0);
    assign last_stage = (o_cur_stage == LAST_STAGE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= HOLD;
            cnt_reg       <= '0;
            o_stage_rst   <= '1;
            o_busy        <= 1'b1;
            o_done        <= 1'b0;
            o_timeout_err <= 1'b0;
            o_cur_stage   <= '0;
        end else if (i_soft_rst) begin
            state_reg     <= HOLD;
            cnt_reg       <= '0;
            o_stage_rst   <= '1;
            o_busy        <= 1'b1;
            o_done        <= 1'b0;
            o_timeout_err <= 1'b0;
            o_cur_stage   <= '0;
        end else begin
            case (state_reg)
                HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        o_stage_rst[0] <= 1'b0;
                        o_cur_stage    <= '0;
                        cnt_reg        <= '0;
                        state_reg      <= WAIT_ACK;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                WAIT_ACK: begin
                    if (stage_end) begin
                        // An ack landing on the timeout edge still counts as on time.
                        if (tmo_hit && !ack_hit)
                            o_timeout_err <= 1'b1;
                        cnt_reg <= '0;
                        if (last_stage) begin
                            state_reg <= DONE;
                            o_done    <= 1'b1;
                            o_busy    <= 1'b0;
                        end else if (STAGE_DLY == 0) begin
                            o_stage_rst <= o_stage_rst & ~(cur_sel << 1);
                            o_cur_stage <= o_cur_stage + SW'(1);
                        end else begin
                            state_reg <= GAP;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        o_stage_rst <= o_stage_rst & ~(cur_sel << 1);
                        o_cur_stage <= o_cur_stage + SW'(1);
                        cnt_reg     <= '0;
                        state_reg   <= WAIT_ACK;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DONE: begin
                    state_reg <= DONE;
                end
                default: begin
                    state_reg <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed table of ack scenarios, hand-written reset
// corner cases and randomized ack timing checked against an edge-schedule model.
module tb_rst_seq_ctrl;

    localparam int NS    = 3;
    localparam int HOLD  = 8;
    localparam int DLY   = 16;
    localparam int TMO   = 255;
    localparam int NEVER = 100000;
    localparam logic [7:0] RESET_VEC = 8'b111_1_0_0_00;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          soft_rst;
    logic [NS-1:0] ack;
    logic [NS-1:0] o_stage_rst;
    logic          o_busy, o_done, o_timeout_err;
    logic [1:0]    o_cur_stage;

    logic          rst2_n;
    logic          soft2 = 1'b0;
    logic [NS-1:0] ack2  = '0;
    logic [NS-1:0] stage_rst2;
    logic          busy2, done2, err2;
    logic [1:0]    cur2;

    rst_seq_ctrl #(
        .NUM_STAGE(NS), .HOLD_CYCLE(HOLD), .STAGE_DLY(DLY), .ACK_TIMEOUT(TMO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_soft_rst(soft_rst), .i_stage_ack(ack),
        .o_stage_rst(o_stage_rst), .o_busy(o_busy), .o_done(o_done),
        .o_timeout_err(o_timeout_err), .o_cur_stage(o_cur_stage)
    );

    rst_seq_ctrl #(
        .NUM_STAGE(NS), .HOLD_CYCLE(8), .STAGE_DLY(0), .ACK_TIMEOUT(0)
    ) dut_fast (
        .i_clk(clk), .i_rst_n(rst2_n), .i_soft_rst(soft2), .i_stage_ack(ack2),
        .o_stage_rst(stage_rst2), .o_busy(busy2), .o_done(done2),
        .o_timeout_err(err2), .o_cur_stage(cur2)
    );

    logic [7:0] out_vec, out2_vec;
    assign out_vec  = {o_stage_rst, o_busy, o_done, o_timeout_err, o_cur_stage};
    assign out2_vec = {stage_rst2, busy2, done2, err2, cur2};

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: ack delay per stage (edges after release), predicted
    // release edge, completion edge and timeout flag.
    int d_cur[NS];
    int r_m[NS];
    int c_m[NS];
    bit e_m[NS];
    int rel_obs[NS];
    int done_obs;

    typedef struct {
        int d0, d1, d2;
        int soft_len;
        int r0, r1, r2;
        int done_e;
        int err;
    } vec_t;

    task automatic check_vec(input string name, input int e, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s edge %0d: got rst/busy/done/err/cur=%b expected %b", name, e, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void model();
        int r;
        r = HOLD;
        for (int k = 0; k < NS; k++) begin
            r_m[k] = r;
            if (TMO == 0) begin
                c_m[k] = r + 1;
                e_m[k] = 1'b0;
            end else if (d_cur[k] <= TMO) begin
                c_m[k] = r + d_cur[k];
                e_m[k] = 1'b0;
            end else begin
                c_m[k] = r + TMO;
                e_m[k] = 1'b1;
            end
            r = c_m[k] + DLY;
        end
    endfunction

    function automatic logic [7:0] exp_vec(input int e);
        logic [NS-1:0] rs;
        logic dn, er;
        int cur;
        er  = 1'b0;
        cur = 0;
        for (int k = 0; k < NS; k++) begin
            rs[k] = (e < r_m[k]);
            if (e_m[k] && e >= c_m[k]) er = 1'b1;
            if (k > 0 && r_m[k] <= e) cur = k;
        end
        dn = (e >= c_m[NS-1]);
        return {rs, ~dn, dn, er, 2'(cur)};
    endfunction

    // Ack for edge n: noise before release, low until the chosen delay,
    // high exactly at it, noise afterwards.
    task automatic drive_ack(input int n);
        int off;
        for (int k = 0; k < NS; k++) begin
            if (rel_obs[k] < 0) begin
                ack[k] = 1'($urandom_range(0, 1));
            end else begin
                off = n - rel_obs[k];
                if (off < d_cur[k])       ack[k] = 1'b0;
                else if (off == d_cur[k]) ack[k] = 1'b1;
                else                      ack[k] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic run_seq(input int a0, input int a1, input int a2, input int soft_len, input int stop_at);
        int last;
        d_cur[0] = a0;
        d_cur[1] = a1;
        d_cur[2] = a2;
        model();
        for (int k = 0; k < NS; k++) rel_obs[k] = -1;
        done_obs = -1;
        ack = NS'($urandom);
        soft_rst = (soft_len > 0);
        for (int s = 1; s <= soft_len; s++) begin
            @(posedge clk); #1;
            check_vec("soft_rst", s, out_vec, RESET_VEC);
            if (s == soft_len) soft_rst = 1'b0;
            ack = NS'($urandom);
        end
        drive_ack(1);
        last = (stop_at > 0) ? stop_at : c_m[NS-1] + 4;
        for (int e = 1; e <= last; e++) begin
            @(posedge clk); #1;
            check_vec("seq", e, out_vec, exp_vec(e));
            for (int k = 0; k < NS; k++)
                if (rel_obs[k] < 0 && !o_stage_rst[k]) rel_obs[k] = e;
            if (done_obs < 0 && o_done) done_obs = e;
            drive_ack(e + 1);
        end
        $display("run ack_dly=%0d/%0d/%0d soft=%0d: release %0d/%0d/%0d done %0d err %0b",
                 a0, a1, a2, soft_len, rel_obs[0], rel_obs[1], rel_obs[2], done_obs, o_timeout_err);
    endtask

    vec_t tbl[4];
    int   choices[10];

    initial begin
        tbl[0] = '{1, 1, 1,     0, 8, 25, 42, 43, 0};
        tbl[1] = '{1, NEVER, 1, 3, 8, 25, 296, 297, 1};
        tbl[2] = '{5, 255, 3,   3, 8, 29, 300, 303, 0};
        tbl[3] = '{256, 1, 2,   1, 8, 279, 296, 298, 1};
        choices = '{1, 2, 3, 7, 15, 30, 254, 255, 256, NEVER};

        rst_n    = 1'b0;
        rst2_n   = 1'b0;
        soft_rst = 1'b0;
        ack      = '0;
        repeat (3) @(posedge clk);
        #1;
        check_vec("por_reset", 0, out_vec, RESET_VEC);
        check_vec("por_reset_fast", 0, out2_vec, RESET_VEC);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_seq(tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].soft_len, 0);
            check_int("release0_edge", rel_obs[0], tbl[i].r0);
            check_int("release1_edge", rel_obs[1], tbl[i].r1);
            check_int("release2_edge", rel_obs[2], tbl[i].r2);
            check_int("done_edge", done_obs, tbl[i].done_e);
            check_int("final_err", int'(o_timeout_err), tbl[i].err);
        end

        // Soft reset in the gap before stage 1, then a clean restart.
        run_seq(1, 1, 1, 2, 15);
        run_seq(1, 1, 1, 2, 0);
        check_int("restart_done_edge", done_obs, 43);

        for (int i = 0; i < 6; i++) begin
            run_seq(choices[$urandom_range(0, 9)], choices[$urandom_range(0, 9)],
                    choices[$urandom_range(0, 9)], int'($urandom_range(1, 4)), 0);
        end

        // Hard reset dropped mid-cycle while stage 1 waits for its ack.
        run_seq(1, NEVER, 1, 1, 100);
        #2 rst_n = 1'b0;
        #1 check_vec("async_rst", 0, out_vec, RESET_VEC);
        @(posedge clk); #1;
        check_vec("async_rst_hold", 0, out_vec, RESET_VEC);
        rst_n = 1'b1;
        run_seq(1, 1, 1, 0, 0);
        check_int("post_rst_done_edge", done_obs, 43);

        // No gap, no ack wait: one stage per edge.
        rst2_n = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            logic [7:0] ex;
            logic [2:0] rs;
            logic       dn;
            logic [1:0] cu;
            @(posedge clk); #1;
            rs = {e < 10, e < 9, e < 8};
            dn = (e >= 11);
            cu = (e >= 10) ? 2'd2 : (e >= 9) ? 2'd1 : 2'd0;
            ex = {rs, ~dn, dn, 1'b0, cu};
            check_vec("fast_seq", e, out2_vec, ex);
        end
        $display("run fast: stages released at edges 8/9/10, done at 11");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
